// File: rtl/scan_frame_capture_if.sv
// -----------------------------------------------------------------------------
// scan_frame_capture_if
//   Bundles the LED matrix scan bus observed by the frame capture block,
//   together with its frame-buffer read port and status outputs.
//
//   Scan bus   : EN, COMM[2:0], red/green/blue[7:0] (active-low column bytes)
//   Control    : freeze (hold the committed buffer, discard completed frames)
//   Read port  : rd_row[2:0], rd_sel[1:0] -> rd_data[7:0] (active-high, registered)
//   Status     : frame_valid, frame_cnt[7:0], sync_err, stall_err, locked
//
//   master : the side that drives the scan bus and the read request
//   slave  : the capture block itself
// -----------------------------------------------------------------------------
interface scan_frame_capture_if;
    logic       EN;
    logic [2:0] COMM;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       freeze;
    logic [2:0] rd_row;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [7:0] frame_cnt;
    logic       sync_err;
    logic       stall_err;
    logic       locked;

    modport master (
        output EN, COMM, red, green, blue, freeze, rd_row, rd_sel,
        input  rd_data, frame_valid, frame_cnt, sync_err, stall_err, locked
    );

    modport slave (
        input  EN, COMM, red, green, blue, freeze, rd_row, rd_sel,
        output rd_data, frame_valid, frame_cnt, sync_err, stall_err, locked
    );
endinterface

// File: rtl/scan_frame_capture.sv
// -----------------------------------------------------------------------------
// scan_frame_capture
//   Receive-side counterpart of the 8x8 LED matrix scan driver. Watches the
//   multiplexed scan bus, rebuilds complete frames row by row in a shadow
//   buffer and copies a frame into the committed buffer only once all eight
//   rows have arrived in order, so a read never sees a torn frame.
//
//   Ports:
//     CLK    : system clock
//     clear  : synchronous active-high reset
//     bus    : scan_frame_capture_if.slave
//              EN/COMM/red/green/blue  scan bus in (colour bytes active-low)
//              freeze                  1 = discard completed frames
//              rd_row/rd_sel           read request (sel 0 R, 1 G, 2 B, 3 OR)
//              rd_data                 selected row, active-high, registered
//              frame_valid             one-cycle pulse on commit
//              frame_cnt               committed frame count (wraps)
//              sync_err                one-cycle pulse on an out-of-order row
//              stall_err               one-cycle pulse on scan timeout
//              locked                  a frame completed since entering CAPTURE
//
//   Parameters:
//     SETTLE  : consecutive equal COMM samples needed before a row is sampled
//     TIMEOUT : cycles without a row sample in CAPTURE before a stall
//     TO_W    : stall counter width
// -----------------------------------------------------------------------------
module scan_frame_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 20000,
    parameter int TO_W    = 16
) (
    input  logic                 CLK,
    input  logic                 clear,
    scan_frame_capture_if.slave  bus
);

    localparam int ST_W = $clog2(SETTLE + 1);

    // Frame storage: [colour][row] with colour 0 red, 1 green, 2 blue.
    typedef logic [2:0][7:0][7:0] frame_t;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    // Row selector for the read port; sel 3 shows any lit colour.
    function automatic logic [7:0] pick_row(input frame_t fb,
                                            input logic [2:0] row,
                                            input logic [1:0] sel);
        logic [7:0] val;
        case (sel)
            2'd0:    val = fb[0][row];
            2'd1:    val = fb[1][row];
            2'd2:    val = fb[2][row];
            2'd3:    val = fb[0][row] | fb[1][row] | fb[2][row];
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Two-stage input synchronisers
    logic            en_q1_r;
    logic            en_sync_r;
    logic [2:0]      comm_q1_r;
    logic [2:0]      comm_sync_r;
    logic [7:0]      red_q1_r;
    logic [7:0]      red_sync_r;
    logic [7:0]      green_q1_r;
    logic [7:0]      green_sync_r;
    logic [7:0]      blue_q1_r;
    logic [7:0]      blue_sync_r;

    // Stability tracking
    logic [2:0]      comm_prev_r;
    logic [ST_W-1:0] stab_r;
    logic [ST_W-1:0] stab_nxt_s;
    logic            sample_s;

    // Frame reconstruction
    state_t          state_r;
    logic [2:0]      expect_r;
    logic [TO_W-1:0] stall_r;
    logic [2:0]      last_row_r;
    logic            last_valid_r;
    frame_t          shadow_r;
    frame_t          shadow_wr_s;
    frame_t          committed_r;

    // Registered outputs
    logic [7:0]      rd_data_r;
    logic            frame_valid_r;
    logic [7:0]      frame_cnt_r;
    logic            sync_err_r;
    logic            stall_err_r;
    logic            locked_r;

    // Input synchronisers and stability counter state
    always_ff @(posedge CLK) begin
        if (clear) begin
            en_q1_r      <= 1'b0;
            en_sync_r    <= 1'b0;
            comm_q1_r    <= 3'd0;
            comm_sync_r  <= 3'd0;
            red_q1_r     <= 8'h00;
            red_sync_r   <= 8'h00;
            green_q1_r   <= 8'h00;
            green_sync_r <= 8'h00;
            blue_q1_r    <= 8'h00;
            blue_sync_r  <= 8'h00;
            comm_prev_r  <= 3'd0;
            stab_r       <= {ST_W{1'b0}};
        end else begin
            en_q1_r      <= bus.EN;
            en_sync_r    <= en_q1_r;
            comm_q1_r    <= bus.COMM;
            comm_sync_r  <= comm_q1_r;
            red_q1_r     <= bus.red;
            red_sync_r   <= red_q1_r;
            green_q1_r   <= bus.green;
            green_sync_r <= green_q1_r;
            blue_q1_r    <= bus.blue;
            blue_sync_r  <= blue_q1_r;
            comm_prev_r  <= comm_sync_r;
            stab_r       <= stab_nxt_s;
        end
    end

    // Stability count and single-cycle sample event. The event fires when the
    // count climbs through SETTLE-1; saturation at SETTLE keeps a row that is
    // simply held from firing again, and the last_row compare keeps a glitch
    // that returns to the same row from re-sampling it.
    always_comb begin
        stab_nxt_s = {ST_W{1'b0}};
        sample_s   = 1'b0;
        if (!en_sync_r || (comm_sync_r != comm_prev_r)) begin
            stab_nxt_s = {ST_W{1'b0}};
        end else if (stab_r == ST_W'(SETTLE)) begin
            stab_nxt_s = stab_r;
        end else begin
            stab_nxt_s = stab_r + 1'b1;
        end
        if (en_sync_r && (stab_nxt_s == ST_W'(SETTLE - 1)) &&
            (!last_valid_r || (comm_sync_r != last_row_r))) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end
    end

    // Shadow buffer with the currently sampled row written in (active-high).
    // Used both for the shadow update and for the commit, so row 7 lands in
    // the committed buffer in the same cycle it is sampled.
    always_comb begin
        shadow_wr_s                 = shadow_r;
        shadow_wr_s[0][comm_sync_r] = ~red_sync_r;
        shadow_wr_s[1][comm_sync_r] = ~green_sync_r;
        shadow_wr_s[2][comm_sync_r] = ~blue_sync_r;
    end

    // Frame capture FSM: row ordering, commit, sync and stall detection
    always_ff @(posedge CLK) begin
        if (clear) begin
            state_r       <= ST_HUNT;
            expect_r      <= 3'd0;
            stall_r       <= {TO_W{1'b0}};
            last_row_r    <= 3'd0;
            last_valid_r  <= 1'b0;
            shadow_r      <= '{default: 8'h00};
            committed_r   <= '{default: 8'h00};
            frame_valid_r <= 1'b0;
            frame_cnt_r   <= 8'd0;
            sync_err_r    <= 1'b0;
            stall_err_r   <= 1'b0;
            locked_r      <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            stall_err_r   <= 1'b0;
            if (sample_s) begin
                last_row_r   <= comm_sync_r;
                last_valid_r <= 1'b1;
            end
            case (state_r)
                ST_HUNT: begin
                    // Other rows are ignored silently while hunting for row 0.
                    stall_r <= {TO_W{1'b0}};
                    if (sample_s && (comm_sync_r == 3'd0)) begin
                        shadow_r <= shadow_wr_s;
                        expect_r <= 3'd1;
                        state_r  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_s) begin
                        stall_r <= {TO_W{1'b0}};
                        if (comm_sync_r == expect_r) begin
                            shadow_r <= shadow_wr_s;
                            expect_r <= expect_r + 3'd1;
                            if (comm_sync_r == 3'd7) begin
                                // Frame complete; a frozen buffer keeps the
                                // old frame but the scan is still in lock.
                                locked_r <= 1'b1;
                                if (!bus.freeze) begin
                                    committed_r   <= shadow_wr_s;
                                    frame_valid_r <= 1'b1;
                                    frame_cnt_r   <= frame_cnt_r + 8'd1;
                                end
                            end
                        end else begin
                            sync_err_r <= 1'b1;
                            locked_r   <= 1'b0;
                            if (comm_sync_r == 3'd0) begin
                                // Out-of-order row 0 is a fresh frame start.
                                shadow_r <= shadow_wr_s;
                                expect_r <= 3'd1;
                            end else begin
                                expect_r <= 3'd0;
                                state_r  <= ST_HUNT;
                            end
                        end
                    end else if (stall_r == TO_W'(TIMEOUT - 1)) begin
                        // Scan stalled: forget the last row so that the same
                        // row can be sampled again once scanning resumes.
                        stall_r      <= {TO_W{1'b0}};
                        stall_err_r  <= 1'b1;
                        locked_r     <= 1'b0;
                        last_valid_r <= 1'b0;
                        expect_r     <= 3'd0;
                        state_r      <= ST_HUNT;
                    end else begin
                        stall_r <= stall_r + 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_HUNT;
                    expect_r <= 3'd0;
                    stall_r  <= {TO_W{1'b0}};
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; sees the committed buffer as it was before any
    // commit happening on the same edge.
    always_ff @(posedge CLK) begin
        if (clear) begin
            rd_data_r <= 8'h00;
        end else begin
            rd_data_r <= pick_row(committed_r, bus.rd_row, bus.rd_sel);
        end
    end

    assign bus.rd_data     = rd_data_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.sync_err    = sync_err_r;
    assign bus.stall_err   = stall_err_r;
    assign bus.locked      = locked_r;

endmodule

// File: doc/scan_frame_capture.md
Name: scan_frame_capture

Overview:
- Receive-side counterpart of the 8x8 LED matrix scan driver.
- Watches the multiplexed scan bus (EN, COMM row index, active-low red/green/blue column bytes) and rebuilds complete frames into an internal frame buffer.
- Exposes the frame through a registered read port, for on-board self-test and game-screen capture such as checking win/lose face patterns.
- Detects scan sequence errors and stalls.

Parameters:
SETTLE, 4, consecutive equal COMM samples required before a row is sampled (min 2)
TIMEOUT, 20000, CLK cycles without a new row sample in CAPTURE before stall is declared
TO_W, 16, width of the stall counter (must hold TIMEOUT)

Ports:
CLK  in  1  system clock
clear  in  1  reset, synchronous, active-high
EN  in  1  scan enable from driver; 0 = display blanked
COMM  in  3  row index currently driven
red  in  8  red column byte, active-low
green  in  8  green column byte, active-low
blue  in  8  blue column byte, active-low
freeze  in  1  1 = completed frames are discarded and the committed buffer is held
rd_row  in  3  read row select
rd_sel  in  2  0 red, 1 green, 2 blue, 3 bitwise OR of all three
rd_data  out  8  selected row, active-high (1 = lit), registered
frame_valid  out  1  one-cycle pulse on frame commit
frame_cnt  out  8  committed frame count, wraps 255->0
sync_err  out  1  one-cycle pulse on out-of-order row
stall_err  out  1  one-cycle pulse on scan timeout
locked  out  1  1 after the first commit since entering CAPTURE

Behaviour:
- Clock and reset: one clock, CLK. Reset clear is synchronous, active-high.
- On clear:
  - State goes to HUNT.
  - Shadow and committed buffers are all 0.
  - rd_data, frame_cnt, frame_valid, sync_err, stall_err and locked are all 0.
  - Stability and stall counters are 0; last_row is invalid.
  - clear mid-frame discards the partial frame.
- Input synchronisation: EN, COMM, red, green and blue pass through two register stages. Logic below uses the synchronised values, so there are 2 cycles of input latency.
- Stability:
  - If COMM_s differs from the previous cycle, or EN_s = 0, stab_cnt resets to 0.
  - Otherwise stab_cnt increments, saturating at SETTLE.
- Sample event: a single-cycle event when stab_cnt reaches SETTLE-1, EN_s = 1, and COMM_s differs from last_row (or last_row is invalid).
  - last_row is set to COMM_s on every sample.
  - A COMM glitch that returns to the same row never re-samples.
  - Colour bytes are inverted on storage (active-high).
- HUNT state:
  - Sample with row 0: write shadow row 0, expect = 1, go to CAPTURE.
  - Samples of other rows are ignored; no error is raised.
- CAPTURE state:
  - Sample with row = expect: write the shadow row and set expect = expect+1 mod 8.
  - Row 7 written: commit. If freeze = 0, copy shadow to committed in the same cycle, pulse frame_valid and increment frame_cnt. If freeze = 1, do not copy, pulse or count. In both cases locked = 1 and the state stays in CAPTURE.
  - Sample with row != expect: pulse sync_err and clear locked. If row = 0, restart (write row 0, expect = 1, stay in CAPTURE); otherwise go to HUNT.
  - Stall counter resets on every sample and increments otherwise. On reaching TIMEOUT: pulse stall_err, clear locked, go to HUNT, invalidate last_row.
- EN_s = 0 blocks sampling but is not an error by itself. The stall counter keeps running.
- Read port:
  - rd_data is registered: it reflects rd_row and rd_sel from the previous cycle.
  - If a commit happens in the same cycle as the read, the read returns the pre-commit data.
  - A torn frame is never visible: only whole frames reach the committed buffer.
- Shadow rows with index >= expect may hold stale data. They are never exposed.

Test Plan:
- Clean scan, rows held 8 cycles each, SETTLE = 4, green row 2 = 8'b01101010 and all other colours 8'hFF -> after row 7: one frame_valid pulse, frame_cnt = 1, locked = 1. Reading rd_row = 2, rd_sel = 1 gives rd_data = 8'b10010101 next cycle; rd_sel = 0 gives 8'h00.
- Scan starts at row 5 -> no frame_valid until the sequence 0..7 that follows the next row 0 completes; no sync_err is raised during HUNT.
- Locked scan jumps from row 2 to row 4 -> one sync_err pulse, state HUNT, locked = 0, committed buffer unchanged. A following clean frame gives frame_cnt +1.
- COMM at row 2 blips to 5 for 2 cycles, then returns to 2 -> no sample and no sync_err; the frame still commits normally.
- COMM frozen at row 4 for 20000 cycles -> one stall_err pulse, locked = 0. Rows 5..7 arriving afterwards are ignored until row 0.
- freeze = 1 over one frame containing new data -> no frame_valid, frame_cnt unchanged, rd_data shows the old frame. Also: with frame_cnt = 255, one more commit gives frame_cnt = 0.
